// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared types for the ysyx_23060201 load/store unit.
// Size encodings, FSM states and the alignment check.
package ysyx_23060201_lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } lsu_state_t;

   function automatic logic misaligned(
      input logic [2:0] lo,
      input logic [1:0] size
   );
      logic bad;
      bad = 1'b0;
      unique case (1'b1)
         (size == SZ_B): bad = 1'b0;
         (size == SZ_H): bad = lo[0];
         (size == SZ_W): bad = |lo[1:0];
         default:        bad = |lo;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// Lane alignment for the LSU: store strobes/shift and
// load extraction with sign or zero extension.
module ysyx_23060201_lsu_align
   import ysyx_23060201_lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [$clog2(DATA_WIDTH/8)-1:0] off,
   input  logic [1:0]                      size,
   input  logic                            wen,
   input  logic                            uns,
   input  logic [DATA_WIDTH-1:0]           wdata,
   input  logic [DATA_WIDTH-1:0]           rdata_raw,
   output logic [DATA_WIDTH/8-1:0]         wstrb,
   output logic [DATA_WIDTH-1:0]           wdata_sh,
   output logic [DATA_WIDTH-1:0]           rdata_ext
);

   localparam int OW = $clog2(DATA_WIDTH/8);

   logic [OW+2:0]         bsh;
   logic [15:0]           mask;
   logic [15:0]           wide;
   logic [6:0]            pad;
   logic [DATA_WIDTH-1:0] sh;
   logic [DATA_WIDTH-1:0] top;

   assign bsh      = {off, 3'b000};
   assign wdata_sh = wdata << bsh;

   always_comb begin
      mask  = (16'd1 << (5'd1 << size)) - 16'd1;
      wide  = mask << off;
      wstrb = wen ? wide[DATA_WIDTH/8-1:0] : '0;
   end

   // Left-justify the field, then shift back to extend it.
   always_comb begin
      pad = '0;
      unique case (1'b1)
         (size == SZ_B): pad = 7'(DATA_WIDTH - 8);
         (size == SZ_H): pad = 7'(DATA_WIDTH - 16);
         (size == SZ_W): pad = 7'(DATA_WIDTH - 32);
         default:        pad = '0;
      endcase
      sh  = rdata_raw >> bsh;
      top = sh << pad;
      if (uns) rdata_ext = top >> pad;
      else     rdata_ext = DATA_WIDTH'($signed(top) >>> pad);
   end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// ysyx_23060201 load/store unit: EXU handshake to req/gnt/rvalid bus.
// Optional watchdog enabled by YSYX_23060201_LSU_TIMEOUT_EN.
module ysyx_23060201_lsu
   import ysyx_23060201_lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_wen,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [1:0]              req_size,
   input  logic                    req_unsigned,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    mem_req,
   input  logic                    mem_gnt,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_rvalid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int OW = $clog2(NB);

   lsu_state_t            state;
   logic                  wen_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;
   logic                  illegal;
   logic                  expire;
   logic [NB-1:0]         wstrb;
   logic [DATA_WIDTH-1:0] wdata_sh;
   logic [DATA_WIDTH-1:0] rdata_ext;

   assign illegal = misaligned(req_addr[2:0], req_size)
                  | ((DATA_WIDTH == 32) & (req_size == SZ_D));

   ysyx_23060201_lsu_align #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_align (
      .off      (addr_q[OW-1:0]),
      .size     (size_q),
      .wen      (wen_q),
      .uns      (uns_q),
      .wdata    (wdata_q),
      .rdata_raw(mem_rdata),
      .wstrb    (wstrb),
      .wdata_sh (wdata_sh),
      .rdata_ext(rdata_ext)
   );

`ifdef YSYX_23060201_LSU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int TW = (CW < 8) ? 8 : CW;
   logic [TW-1:0] cnt;

   assign expire = (cnt >= TW'(TIMEOUT - 1));

   // Saturates so a grant on the expiring edge still times out in WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cnt <= '0;
      else if (state == S_IDLE)   cnt <= '0;
      else if (state != S_RESP && cnt != TW'(TIMEOUT))
                                  cnt <= cnt + 1'b1;
   end
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: if (req_valid) begin
               wen_q   <= req_wen;
               addr_q  <= req_addr;
               size_q  <= req_size;
               uns_q   <= req_unsigned;
               wdata_q <= req_wdata;
               rdata_q <= '0;
               err_q   <= illegal;
               state   <= illegal ? S_RESP : S_REQ;
            end
            S_REQ: if (mem_gnt) begin
               state <= S_WAIT;
            end else if (expire) begin
               err_q <= 1'b1;
               state <= S_RESP;
            end
            S_WAIT: if (mem_rvalid) begin
               rdata_q <= wen_q ? '0 : rdata_ext;
               err_q   <= 1'b0;
               state   <= S_RESP;
            end else if (expire) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
               state   <= S_RESP;
            end
            S_RESP: if (rsp_ready) begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = rst_n & (state == S_IDLE);
   assign mem_req   = (state == S_REQ);
   assign mem_we    = mem_req & wen_q;
   assign mem_addr  = mem_req ? {addr_q[ADDR_WIDTH-1:OW], {OW{1'b0}}} : '0;
   assign mem_wstrb = mem_req ? wstrb : '0;
   assign mem_wdata = mem_req ? wdata_sh : '0;
   assign rsp_valid = (state == S_RESP);
   assign rsp_rdata = rsp_valid ? rdata_q : '0;
   assign rsp_err   = rsp_valid & err_q;

endmodule

// File: doc/ysyx_23060201_lsu.md
# ysyx_23060201_lsu

Parametrised load/store unit between the EXU and the data-memory bus of the ysyx_23060201 core, replacing the fixed single-cycle memory access path. It accepts one load or store at a time over a valid/ready handshake and generates byte strobes and lane-shifted write data. It talks to a request/grant/response memory bus with arbitrary wait states and returns lane-extracted, sign- or zero-extended load data. Misaligned accesses are trapped locally and never reach the bus.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, bus/data width; 32 or 64 only
- TIMEOUT, 255, watchdog limit in cycles (used only with the timeout feature)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  EXU request valid
- req_ready  out  1  LSU can accept; high only in IDLE
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  EXU accepts response
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size, or timeout
- mem_req  out  1  bus request, held until mem_gnt
- mem_gnt  in  1  bus grant
- mem_we  out  1  bus write
- mem_addr  out  ADDR_WIDTH  address with lane-offset bits forced to 0
- mem_wstrb  out  DATA_WIDTH/8  byte strobes
- mem_wdata  out  DATA_WIDTH  lane-shifted write data
- mem_rvalid  in  1  bus response (read data or write ack)
- mem_rdata  in  DATA_WIDTH  bus read data

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: capture wen/addr/size/unsigned/wdata.
  - Legal access -> REQ.
  - Misaligned (addr not a multiple of 2^size) or size 11 with DATA_WIDTH=32 -> RESP with rsp_err=1, rsp_rdata=0.
- REQ: mem_req=1 with stable mem_we/addr/wstrb/wdata. mem_gnt -> WAIT.
- WAIT: on mem_rvalid, latch extracted data (loads) or 0 (stores); rsp_err=0 -> RESP.
- RESP: rsp_valid=1; rsp_ready -> IDLE. A new request is accepted no earlier than the cycle after the handshake.
- Lane offset off = addr[log2(DATA_WIDTH/8)-1:0].
  - wstrb = ((1<<2^size)-1) << off; 0 for loads.
  - wdata = req_wdata << 8*off.
  - rdata = (mem_rdata >> 8*off) truncated to 8·2^size bits, then extended to DATA_WIDTH per req_unsigned.
  - Size 10 on DATA_WIDTH=32 is full width, so extension is a no-op.
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.

## Timing
- Reset, async assert: state=IDLE; req_ready=1 once rst_n is high; all other outputs 0; captured registers 0.
- Reset mid-transaction aborts it with no response. The bus master must tolerate the dropped request.
- Best case, legal access: accept at edge 0, mem_req high in cycle 1, mem_gnt in cycle 1, mem_rvalid in cycle 2, rsp_valid in cycle 3.
- Best case, misaligned access: rsp_valid in the cycle after accept.
- All outputs are registered-state decodes. No combinational path runs from req_* or mem_* to any output except through state.

## Configuration
- YSYX_23060201_LSU_TIMEOUT_EN defined:
  - An 8..16-bit counter (clog2(TIMEOUT+1)) clears on entry to REQ and increments in REQ/WAIT.
  - When it reaches TIMEOUT: mem_req drops, state goes to RESP with rsp_err=1, rsp_rdata=0.
  - A late mem_rvalid is ignored.
- Not defined: no counter; the LSU waits indefinitely in REQ/WAIT.

## Structure
- Package ysyx_23060201_lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - state enum lsu_state_t
  - function for the misalignment check
- Sub-module ysyx_23060201_lsu_align, combinational:
  - store path: strobe and write-data shift
  - load path: extraction and sign/zero extension
- The FSM, capture registers and watchdog stay in ysyx_23060201_lsu.

## Test plan
- DATA_WIDTH=32, store byte 0xA5 to 0x8000_0003 -> mem_addr 0x8000_0000, wstrb 1000, wdata 0xA500_0000; rsp_err 0 after mem_rvalid.
- Load half, signed, from 0x8000_0002, mem_rdata 0x8001_1234 -> rsp_rdata 0xFFFF_8001; same with req_unsigned=1 -> 0x0000_8001.
- Load word from 0x8000_0001 -> no mem_req ever; rsp_valid the cycle after accept, rsp_err 1, rsp_rdata 0.
- mem_gnt delayed 5 cycles, rsp_ready delayed 3 cycles -> mem_req and bus fields stable throughout; rsp_valid and rsp_rdata held; req_ready low until handshake.
- TIMEOUT_EN with TIMEOUT=10, no mem_rvalid -> rsp_err 1 exactly 10 cycles after entering REQ; a later mem_rvalid has no effect.
- rst_n pulsed low while in WAIT -> all outputs 0 immediately; after release req_ready=1 and the next load completes normally.
